// File: rtl/ram_pkg.sv
// Shared types and helpers for the banked block RAM.
// Consumed by banked_ram and banked_ram_bank.
package ram_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        CLEAR,
        RUN
    } ram_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/banked_ram_bank.sv
// One BANK_DEPTH x DATA_WIDTH bank built from independent byte lanes with a
// holding output register; each lane maps onto one SB_RAM512x8 at depth 512.
module banked_ram_bank
    import ram_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int BANK_DEPTH = 512,
    localparam int WORD_W     = clog2(BANK_DEPTH),
    localparam int LANES      = DATA_WIDTH / BYTE_W
) (
    input  logic                  CLK,
    input  logic [LANES-1:0]      WBE,
    input  logic [WORD_W-1:0]     WADDR,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  RE,
    input  logic [WORD_W-1:0]     RADDR,
    output logic [DATA_WIDTH-1:0] RDATA
);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [BYTE_W-1:0] mem [BANK_DEPTH];
        logic [BYTE_W-1:0] rd_q;

        // NOTE: the array has no reset so it still maps onto block RAM; the
        // top-level clear sweep zeroes it after every reset instead.
        always_ff @(posedge CLK) begin
            if (WBE[l]) begin
                mem[WADDR] <= WDATA[l*BYTE_W +: BYTE_W];
            end
            if (RE) begin
                rd_q <= mem[RADDR];
            end
        end

        assign RDATA[l*BYTE_W +: BYTE_W] = rd_q;
    end

endmodule

// File: rtl/banked_ram.sv
// Parametrised banked RAM with per-byte writes, post-reset clear sweep and
// range errors. Define BANKED_RAM_WR_BYPASS_EN for same-address write bypass.
module banked_ram
    import ram_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int BANK_COUNT = 3,
    parameter  int BANK_DEPTH = 512,
    localparam int ADDR_WIDTH = clog2(BANK_COUNT * BANK_DEPTH)
) (
    input  logic                         CLK,
    input  logic                         RST,
    output logic                         READY,
    input  logic                         RE,
    input  logic [ADDR_WIDTH-1:0]        RADDR,
    output logic [DATA_WIDTH-1:0]        RDATA,
    output logic                         RVALID,
    output logic                         RERR,
    input  logic                         WE,
    input  logic [ADDR_WIDTH-1:0]        WADDR,
    input  logic [DATA_WIDTH-1:0]        WDATA,
    input  logic [DATA_WIDTH/BYTE_W-1:0] WBE,
    output logic                         WERR
);

    localparam int LANES  = DATA_WIDTH / BYTE_W;
    localparam int WORD_W = clog2(BANK_DEPTH);
    localparam int BANK_W = (ADDR_WIDTH > WORD_W) ? ADDR_WIDTH - WORD_W : 1;
    localparam logic [ADDR_WIDTH:0] WORDS_EXT = (ADDR_WIDTH + 1)'(BANK_COUNT * BANK_DEPTH);

    ram_state_e            state;
    logic [WORD_W-1:0]     clr_cnt;
    logic                  rd_fire, wr_fire, rd_oor, wr_oor;
    logic [BANK_W-1:0]     rd_bank, wr_bank, rsel_q;
    logic                  rzero_q;
    logic [WORD_W-1:0]     mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata, mux_data, resp_data;
    logic [DATA_WIDTH-1:0] bank_rdata [BANK_COUNT];

    assign rd_fire = RE && READY;
    assign wr_fire = WE && READY;
    assign rd_oor  = {1'b0, RADDR} >= WORDS_EXT;
    assign wr_oor  = {1'b0, WADDR} >= WORDS_EXT;
    assign rd_bank = BANK_W'(RADDR >> WORD_W);
    assign wr_bank = BANK_W'(WADDR >> WORD_W);

    // The sweep owns the shared write port of every bank until READY rises.
    assign mem_waddr = (state == CLEAR) ? clr_cnt : WADDR[WORD_W-1:0];
    assign mem_wdata = (state == CLEAR) ? '0 : WDATA;

    for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
        logic [LANES-1:0] bank_wbe;
        logic             bank_re;

        assign bank_wbe = (state == CLEAR) ? '1 :
                          (wr_fire && !wr_oor && wr_bank == BANK_W'(b)) ? WBE : '0;
        assign bank_re  = rd_fire && !rd_oor && rd_bank == BANK_W'(b);

        banked_ram_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .BANK_DEPTH (BANK_DEPTH)
        ) u_bank (
            .CLK   (CLK),
            .WBE   (bank_wbe),
            .WADDR (mem_waddr),
            .WDATA (mem_wdata),
            .RE    (bank_re),
            .RADDR (RADDR[WORD_W-1:0]),
            .RDATA (bank_rdata[b])
        );
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            READY   <= 1'b0;
            RVALID  <= 1'b0;
            RERR    <= 1'b0;
            WERR    <= 1'b0;
            rsel_q  <= '0;
            rzero_q <= 1'b1;
        end else begin
            RVALID <= rd_fire;
            RERR   <= rd_fire && rd_oor;
            WERR   <= wr_fire && wr_oor;
            if (rd_fire) begin
                rsel_q  <= rd_bank;
                rzero_q <= rd_oor;
            end
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == WORD_W'(BANK_DEPTH - 1)) begin
                        READY <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: state <= RUN;
                default: state <= CLEAR;
            endcase
        end
    end

    // NOTE: the default before the loop keeps this block free of latches.
    always_comb begin
        mux_data = '0;
        for (int b = 0; b < BANK_COUNT; b++) begin
            if (rsel_q == BANK_W'(b)) begin
                mux_data = bank_rdata[b];
            end
        end
    end

`ifdef BANKED_RAM_WR_BYPASS_EN
    logic [DATA_WIDTH-1:0] wbe_bits, byp_mask, byp_data;

    always_comb begin
        wbe_bits = '0;
        for (int i = 0; i < LANES; i++) begin
            wbe_bits[i*BYTE_W +: BYTE_W] = {BYTE_W{WBE[i]}};
        end
    end

    // Bytes written alongside a same-address read are taken from the write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            byp_mask <= '0;
            byp_data <= '0;
        end else if (rd_fire) begin
            byp_mask <= (wr_fire && !wr_oor && WADDR == RADDR) ? wbe_bits : '0;
            byp_data <= WDATA;
        end
    end

    assign resp_data = (mux_data & ~byp_mask) | (byp_data & byp_mask);
`else
    assign resp_data = mux_data;
`endif

    // Bank output registers hold between reads; rzero_q covers reset and errors.
    assign RDATA = rzero_q ? '0 : resp_data;

endmodule
